// File: rtl/apb_master.sv
// APB requester: turns single-beat local commands into IDLE/SETUP/ACCESS transfers
// toward two slaves selected by the top address bit, with optional ACCESS timeout.
module apb_master #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_done,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-2:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY1,
  input  logic              PREADY2,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic [DATA_W-1:0] PRDATA2,
  output logic [1:0]        dbg_state
);

  // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so the controller holds its command otherwise.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t            state;
  state_t            state_nxt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CW-1:0]     wait_cnt;

  logic              sel2;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;
  logic              timeout_hit;

  // Only the addressed slave's ready/data are ever looked at.
  assign sel2        = addr_q[ADDR_W-1];
  assign sel_ready   = sel2 ? PREADY2 : PREADY1;
  assign sel_rdata   = sel2 ? PRDATA2 : PRDATA1;
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == LAST);

  assign PWRITE = wr_q;
  assign PADDR  = addr_q[ADDR_W-2:0];
  assign PWDATA = wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wait_cnt  <= '0;
      rsp_done  <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state    <= state_nxt;
      rsp_done <= 1'b0;
      rsp_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wr_q    <= cmd_write;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
          end
        end
        SETUP: wait_cnt <= '0;
        ACCESS: begin
          if (sel_ready) begin
            rsp_done <= 1'b1;
            if (!wr_q) rsp_rdata <= sel_rdata;
          end else if (timeout_hit) begin
            rsp_done <= 1'b1;
            rsp_err  <= 1'b1;
          end else if (TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (sel_ready || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    PSEL1     = (state != IDLE) && !sel2;
    PSEL2     = (state != IDLE) && sel2;
    PENABLE   = (state == ACCESS);
    dbg_state = state;
  end

endmodule
